// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer for an iCE40 SB_PLL40_CORE.
// Pulses the PLL reset, waits for a synchronised LOCK, holds the design reset until lock has
// been stable, retries on lock timeout and restarts on loss of lock. Runs on the PLL
// reference clock only.
// Optional feature: define PLL_LOCK_SEQ_BYPASS_FALLBACK_EN to fall back to PLL bypass (design
// runs on the reference clock) instead of parking in FAIL when retries are exhausted.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       rst,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int unsigned MaxRt   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MaxCyc  = (MaxRt > STABLE_CYCLES) ? MaxRt : STABLE_CYCLES;
    localparam int unsigned CntW    = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] ResetLast   = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [4:0]      MaxRetries  = 5'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
        ,
        StBypass
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [4:0]      retry_inc;
    logic            sync1_q, lock_s;

    logic resetb_q, resetb_d;
    logic rst_q, rst_d;
    logic locked_q, locked_d;
    logic fail_q, fail_d;

    // Two-flop synchroniser for the asynchronous PLL LOCK pin.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            lock_s  <= sync1_q;
        end
    end

    // State, shared counter and retry counter registers.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StResetPll;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state, counter and retry bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        retry_d   = retry_q;
        // Unsaturated increment so MAX_RETRIES=15 can still be exceeded.
        retry_inc = {1'b0, retry_q} + 5'd1;
        unique case (state_q)
            StResetPll: begin
                if (cnt_q == ResetLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = (retry_q == 4'hF) ? retry_q : retry_inc[3:0];
                    if (retry_inc > MaxRetries) begin
`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
                        state_d = StBypass;
`else
                        state_d = StFail;
`endif
                    end else begin
                        state_d = StResetPll;
                    end
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = StResetPll;
                end
            end
            StFail: begin
                cnt_d = '0;
            end
`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
            StBypass: begin
                // Count up to the release point, then hold.
                if (cnt_q == StableLast) begin
                    cnt_d = cnt_q;
                end
            end
`endif
            default: begin
                state_d = StResetPll;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Output decode from the next state so outputs change on the same edge as the state.
    always_comb begin
        resetb_d = 1'b0;
        rst_d    = 1'b1;
        locked_d = 1'b0;
        fail_d   = 1'b0;
        unique case (state_d)
            StResetPll: resetb_d = 1'b0;
            StWaitLock: resetb_d = 1'b1;
            StStable:   resetb_d = 1'b1;
            StRun: begin
                resetb_d = 1'b1;
                rst_d    = 1'b0;
                locked_d = 1'b1;
            end
            StFail:     fail_d   = 1'b1;
`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
            StBypass: begin
                resetb_d = 1'b1;
                fail_d   = 1'b1;
                rst_d    = !((state_q == StBypass) && (cnt_q == StableLast));
            end
`endif
            default:    resetb_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            resetb_q <= 1'b0;
            rst_q    <= 1'b1;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            resetb_q <= resetb_d;
            rst_q    <= rst_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
    logic bypass_q;

    // Bypass pin register, high only in the fallback state.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= (state_d == StBypass);
        end
    end

    assign pll_bypass = bypass_q;
`else
    assign pll_bypass = 1'b0;
`endif

    assign pll_resetb  = resetb_q;
    assign rst         = rst_q;
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a table of lock-input segments with the
// expected outputs for each cycle, fed through a scoreboard queue and checked one cycle later.
module tb_pll_lock_sequencer;

    logic       clock_in = 1'b0;
    logic       rst_n    = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       rst;
    logic       locked;
    logic       fail;
    logic [3:0] retry_count;

    pll_lock_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clock_in    (clock_in),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .rst         (rst),
        .locked      (locked),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic       resetb;
        logic       rst;
        logic       locked;
        logic       fail;
        logic       bypass;
        logic [3:0] retry;
    } exp_t;

    typedef struct {
        bit   is_reset;
        logic lock;
        int   n;
        exp_t e;
    } seg_t;

    seg_t plan[$];
    exp_t sb[$];
    exp_t act;
    exp_t mon_exp;
    int   total  = 0;
    int   passed = 0;
    int   step   = 0;

    assign act = {pll_resetb, rst, locked, fail, pll_bypass, retry_count};

    function automatic exp_t mk(logic rb, logic r, logic l, logic f, logic b, logic [3:0] rc);
        exp_t x;
        x.resetb = rb;
        x.rst    = r;
        x.locked = l;
        x.fail   = f;
        x.bypass = b;
        x.retry  = rc;
        return x;
    endfunction

    function automatic void add_run(logic lock, int n, exp_t e);
        seg_t s;
        s.is_reset = 1'b0;
        s.lock     = lock;
        s.n        = n;
        s.e        = e;
        plan.push_back(s);
    endfunction

    function automatic void add_reset();
        seg_t s;
        s.is_reset = 1'b1;
        s.lock     = 1'b0;
        s.n        = 0;
        s.e        = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        plan.push_back(s);
    endfunction

    task automatic check(input exp_t exp, input string what);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d t=%0t: got resetb=%b rst=%b locked=%b fail=%b bypass=%b retry=%0d, want resetb=%b rst=%b locked=%b fail=%b bypass=%b retry=%0d",
                     what, step, $time, act.resetb, act.rst, act.locked, act.fail, act.bypass,
                     act.retry, exp.resetb, exp.rst, exp.locked, exp.fail, exp.bypass, exp.retry);
        end
    endtask

    // Scoreboard consumer: compare each cycle's outputs just after the clock edge.
    always @(posedge clock_in) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            step++;
            check(mon_exp, "cycle");
        end
    end

    initial begin
        exp_t p0, w0, run0;
        p0   = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        w0   = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        run0 = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Normal bring-up, then a one-cycle lock drop in RUN and re-lock.
        add_reset();
        add_run(1'b0, 3,  p0);
        add_run(1'b0, 7,  w0);
        add_run(1'b1, 10, w0);
        add_run(1'b1, 5,  run0);
        add_run(1'b0, 1,  run0);
        add_run(1'b1, 1,  run0);
        add_run(1'b1, 4,  p0);
        add_run(1'b1, 9,  w0);
        add_run(1'b1, 3,  run0);

        // Lock bounce in STABLE: high 5, low 2, then steady.
        add_reset();
        add_run(1'b0, 3,  p0);
        add_run(1'b0, 4,  w0);
        add_run(1'b1, 5,  w0);
        add_run(1'b0, 2,  w0);
        add_run(1'b1, 10, w0);
        add_run(1'b1, 3,  run0);

        // Reset asserted in WAIT_LOCK with counter at 20, then restart.
        add_reset();
        add_run(1'b0, 3,  p0);
        add_run(1'b0, 21, w0);
        add_reset();
        add_run(1'b0, 3,  p0);
        add_run(1'b0, 2,  w0);

        // Lock never arrives: three reset pulses, then FAIL (or BYPASS fallback).
        add_reset();
        add_run(1'b0, 3,  p0);
        add_run(1'b0, 32, w0);
        add_run(1'b0, 4,  mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1));
        add_run(1'b0, 32, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1));
        add_run(1'b0, 4,  mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2));
        add_run(1'b0, 32, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2));
`ifdef PLL_LOCK_SEQ_BYPASS_FALLBACK_EN
        add_run(1'b0, 8,  mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3));
        add_run(1'b0, 6,  mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3));
`else
        add_run(1'b0, 10, mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3));
`endif
        // Reset clears the sticky fail.
        add_reset();

        #1;
        for (int i = 0; i < plan.size(); i++) begin
            if (plan[i].is_reset) begin
                rst_n    = 1'b0;
                pll_lock = 1'b0;
                #1;
                check(plan[i].e, "async_reset");
                @(posedge clock_in);
                #2;
                rst_n = 1'b1;
            end else begin
                for (int k = 0; k < plan[i].n; k++) begin
                    pll_lock = plan[i].lock;
                    sb.push_back(plan[i].e);
                    @(posedge clock_in);
                    #2;
                end
            end
        end

        total++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at t=%0t, want completion", $time);
        $fatal(1);
    end

endmodule
